// File: rtl/trace_pkg.sv
// Purpose: shared tags, drop-tracking state and entry layout for the trace buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trace_pkg;

    // Widths of the default build; the entry struct below is laid out with these.
    localparam int DATA_W = 32;
    localparam int TS_W   = 24;

    // Tag bit distinguishes captured events from lost-event markers.
    localparam logic TAG_EVENT = 1'b0;
    localparam logic TAG_DROP  = 1'b1;

    typedef enum logic {
        NORMAL   = 1'b0,
        DROPPING = 1'b1
    } drop_state_t;

    // Entry = {tag, timestamp, payload}, tag in the MSB.
    typedef struct packed {
        logic              tag;
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Purpose: single-clock FIFO holding trace entries, with synchronous flush.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: pushes are ignored when full; pops are ignored when empty.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 57,
    localparam int CW   = $clog2(DEPTH+1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_push     = i_push & ~o_full & ~i_flush;
    assign w_pop      = i_pop & ~o_empty & ~i_flush;
    // Head is forced to zero when empty so stale storage never leaks out.
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/monitor_trace_buffer.sv
// Purpose: timestamp rising edges of the SoC monitor level and queue them, reporting lost events with markers.
// Latency: edge in cycle N shows as a valid head entry in cycle N+1.
// Backpressure: when full, events are counted as drops and a marker is queued once a slot opens.
module monitor_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 24,
    parameter int DEPTH      = 8,
    localparam int ENTRY_W   = 1 + TS_WIDTH + DATA_WIDTH,
    localparam int FILL_W    = $clog2(DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  monitor_valid_i,
    input  logic [DATA_WIDTH-1:0] event_data_i,
    output logic                  trace_valid_o,
    input  logic                  trace_ready_i,
    output logic [ENTRY_W-1:0]    trace_data_o,
    output logic [FILL_W-1:0]     fill_level_o,
    output logic                  overflow_o
);

    logic                  r_valid_q;
    logic [TS_WIDTH-1:0]   r_ts;
    drop_state_t           r_state;
    logic [DATA_WIDTH-1:0] r_drop_cnt;
    logic                  r_overflow;

    logic                  w_edge;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic [ENTRY_W-1:0]    w_push_dat;

    assign w_edge        = monitor_valid_i & ~r_valid_q & enable_i;
    assign w_pop         = trace_valid_o & trace_ready_i;
    assign trace_valid_o = ~w_empty;
    assign overflow_o    = r_overflow;

    // Select what (if anything) enters the FIFO: an event in NORMAL, a marker in DROPPING.
    always_comb begin
        w_push     = 1'b0;
        w_push_dat = '0;
        if (!clear_i && !w_full) begin
            if (r_state == NORMAL) begin
                w_push     = w_edge;
                w_push_dat = {TAG_EVENT, r_ts, event_data_i};
            end else begin
                w_push     = 1'b1;
                w_push_dat = {TAG_DROP, r_ts, r_drop_cnt};
            end
        end
    end

    // Previous monitor level; sampled even during clear so a held level makes no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_valid_q <= 1'b0;
        else     r_valid_q <= monitor_valid_i;
    end

    // Free-running timestamp, frozen while capture is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_ts <= '0;
        else if (clear_i)  r_ts <= '0;
        else if (enable_i) r_ts <= r_ts + 1'b1;
    end

    // Drop tracking: count events lost while full, hand off to a marker when space appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= NORMAL;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_state    <= NORMAL;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (w_edge && w_full) begin
                        r_drop_cnt <= DATA_WIDTH'(1);
                        r_overflow <= 1'b1;
                        r_state    <= DROPPING;
                    end
                end
                DROPPING: begin
                    if (!w_full) begin
                        // The marker uses this cycle's slot, so a coinciding edge is itself lost.
                        if (w_edge) begin
                            r_drop_cnt <= DATA_WIDTH'(1);
                        end else begin
                            r_drop_cnt <= '0;
                            r_state    <= NORMAL;
                        end
                    end else if (w_edge && (r_drop_cnt != '1)) begin
                        r_drop_cnt <= r_drop_cnt + 1'b1;
                    end
                end
                default: r_state <= NORMAL;
            endcase
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (clear_i),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (trace_data_o),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (fill_level_o)
    );

endmodule

// File: tb/tb_monitor_trace_buffer.sv
// Purpose: directed plus randomised-backpressure bench with an entry scoreboard.
// Latency: checks head entries at the cycle they are accepted.
// Backpressure: trace_ready_i is driven by the stimulus, including random stalls.
module tb_monitor_trace_buffer;
    import trace_pkg::*;

    localparam int DW  = 32;
    localparam int TW  = 24;
    localparam int DEP = 8;
    localparam int EW  = 1 + TW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic          clear_i;
    logic          monitor_valid_i;
    logic [DW-1:0] event_data_i;
    logic          trace_valid_o;
    logic          trace_ready_i;
    logic [EW-1:0] trace_data_o;
    logic [3:0]    fill_level_o;
    logic          overflow_o;

    // Second instance with a 4-bit timestamp for the wrap case.
    logic          b_en;
    logic          b_clr;
    logic          b_mv;
    logic [31:0]   b_dat;
    logic          b_vld;
    logic          b_rdy;
    logic [36:0]   b_out;
    logic [2:0]    b_fill;
    logic          b_ovf;

    always #5 clk = ~clk;

    monitor_trace_buffer #(.DATA_WIDTH(DW), .TS_WIDTH(TW), .DEPTH(DEP)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (enable_i),
        .clear_i         (clear_i),
        .monitor_valid_i (monitor_valid_i),
        .event_data_i    (event_data_i),
        .trace_valid_o   (trace_valid_o),
        .trace_ready_i   (trace_ready_i),
        .trace_data_o    (trace_data_o),
        .fill_level_o    (fill_level_o),
        .overflow_o      (overflow_o)
    );

    monitor_trace_buffer #(.DATA_WIDTH(32), .TS_WIDTH(4), .DEPTH(4)) u_wrap (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (b_en),
        .clear_i         (b_clr),
        .monitor_valid_i (b_mv),
        .event_data_i    (b_dat),
        .trace_valid_o   (b_vld),
        .trace_ready_i   (b_rdy),
        .trace_data_o    (b_out),
        .fill_level_o    (b_fill),
        .overflow_o      (b_ovf)
    );

    int            n_checks = 0;
    int            n_err    = 0;
    int            n_pops   = 0;
    logic [EW-1:0] sb [$];
    logic [TW-1:0] m_ts;
    logic [3:0]    b_ts;

    function automatic logic [EW-1:0] ent(input logic tag, input logic [TW-1:0] ts, input logic [DW-1:0] d);
        trace_entry_t e;
        e.tag  = tag;
        e.ts   = ts;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any accepted entry, advance the timestamp models, check stall stability.
    task automatic step();
        logic          stalled;
        logic [EW-1:0] held;
        stalled = trace_valid_o && !trace_ready_i;
        held    = trace_data_o;
        if (trace_valid_o && trace_ready_i) begin
            chk("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                chk("sb_entry", 64'(trace_data_o), 64'(sb[0]));
                void'(sb.pop_front());
                n_pops++;
            end
        end
        @(posedge clk);
        if (clear_i)       m_ts = '0;
        else if (enable_i) m_ts = m_ts + 1'b1;
        if (b_clr)         b_ts = '0;
        else if (b_en)     b_ts = b_ts + 1'b1;
        #1;
        if (stalled && trace_valid_o) chk("stall_stable", 64'(trace_data_o), 64'(held));
    endtask

    // Rising edge with payload d, then back low; exp_push says whether it should be captured.
    task automatic ev(input logic [DW-1:0] d, input bit exp_push);
        monitor_valid_i = 1'b1;
        event_data_i    = d;
        if (exp_push) sb.push_back(ent(TAG_EVENT, m_ts, d));
        step();
        monitor_valid_i = 1'b0;
        step();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && sb.size() != 0; i++) step();
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({tag, "_fill"}, 64'(fill_level_o), 64'd0);
    endtask

    initial begin
        int p0;
        rst = 1'b1; enable_i = 1'b0; clear_i = 1'b0; monitor_valid_i = 1'b0;
        event_data_i = '0; trace_ready_i = 1'b0;
        b_en = 1'b0; b_clr = 1'b0; b_mv = 1'b0; b_dat = '0; b_rdy = 1'b0;
        m_ts = '0; b_ts = '0;
        #12;
        chk("rst_valid", 64'(trace_valid_o), 64'd0);
        chk("rst_data", 64'(trace_data_o), 64'd0);
        chk("rst_fill", 64'(fill_level_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single event at ts 100.
        enable_i = 1'b1; trace_ready_i = 1'b1;
        for (int i = 0; i < 200 && m_ts != TW'(100); i++) step();
        monitor_valid_i = 1'b1; event_data_i = 32'hDEADBEEF;
        sb.push_back(ent(TAG_EVENT, 24'd100, 32'hDEADBEEF));
        step();
        chk("single_valid", 64'(trace_valid_o), 64'd1);
        chk("single_fill1", 64'(fill_level_o), 64'd1);
        chk("single_data", 64'(trace_data_o), {7'd0, 1'b0, 24'd100, 32'hDEADBEEF});
        monitor_valid_i = 1'b0;
        step();
        chk("single_fill0", 64'(fill_level_o), 64'd0);
        chk("single_pops", 64'(n_pops), 64'd1);

        // Held level yields one entry; a disabled edge yields nothing and freezes ts.
        p0 = n_pops;
        monitor_valid_i = 1'b1;
        sb.push_back(ent(TAG_EVENT, m_ts, 32'h10));
        for (int i = 0; i < 10; i++) begin
            event_data_i = 32'h10 + 32'(i);
            step();
        end
        monitor_valid_i = 1'b0;
        step(); step();
        chk("held_pops", 64'(n_pops - p0), 64'd1);
        enable_i = 1'b0;
        step();
        monitor_valid_i = 1'b1; event_data_i = 32'hBAD;
        step(); step();
        monitor_valid_i = 1'b0;
        step();
        chk("dis_fill", 64'(fill_level_o), 64'd0);
        chk("dis_ovf", 64'(overflow_o), 64'd0);
        enable_i = 1'b1;
        ev(32'hC0FFEE, 1'b1);
        drain("dis");

        // Overflow: 11 edges into 8 slots, then a marker carrying 3.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 11; i++) ev(32'h100 + 32'(i), i < 8);
        chk("ovf_fill", 64'(fill_level_o), 64'd8);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        trace_ready_i = 1'b1;
        step();
        sb.push_back(ent(TAG_DROP, m_ts, 32'd3));
        drain("ovf");
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Edge in the marker cycle: marker carries 2, a second marker carries 1.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) ev(32'h200 + 32'(i), i < 8);
        trace_ready_i = 1'b1;
        step();
        trace_ready_i = 1'b0;
        monitor_valid_i = 1'b1; event_data_i = 32'h5555;
        sb.push_back(ent(TAG_DROP, m_ts, 32'd2));
        step();
        monitor_valid_i = 1'b0;
        step();
        chk("coll_fill", 64'(fill_level_o), 64'd8);
        trace_ready_i = 1'b1;
        step();
        sb.push_back(ent(TAG_DROP, m_ts, 32'd1));
        drain("coll");

        // Clear while full and dropping.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) ev(32'h300 + 32'(i), i < 8);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        sb.delete();
        chk("clr_valid", 64'(trace_valid_o), 64'd0);
        chk("clr_fill", 64'(fill_level_o), 64'd0);
        chk("clr_ovf", 64'(overflow_o), 64'd0);
        trace_ready_i = 1'b1;
        monitor_valid_i = 1'b1; event_data_i = 32'h1234;
        sb.push_back(ent(TAG_EVENT, 24'd0, 32'h1234));
        step();
        monitor_valid_i = 1'b0;
        drain("clr_ts0");
        monitor_valid_i = 1'b1; clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        step(); step(); step();
        chk("clr_level_valid", 64'(trace_valid_o), 64'd0);
        chk("clr_level_fill", 64'(fill_level_o), 64'd0);
        monitor_valid_i = 1'b0;
        step();

        // Random backpressure: every event appears once, in order, stable while stalled.
        for (int i = 0; i < 30; i++) begin
            monitor_valid_i = 1'b1;
            event_data_i    = $urandom;
            sb.push_back(ent(TAG_EVENT, m_ts, event_data_i));
            trace_ready_i   = ($urandom_range(0, 3) != 0);
            step();
            monitor_valid_i = 1'b0;
            for (int j = 0; j < 3; j++) begin
                trace_ready_i = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        trace_ready_i = 1'b1;
        drain("rand");
        chk("rand_ovf", 64'(overflow_o), 64'd0);

        // Timestamp wrap on the 4-bit instance: edges at ts 15 and at ts 0 of the next lap.
        b_en = 1'b1; b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        for (int i = 0; i < 40 && b_ts != 4'd15; i++) step();
        b_mv = 1'b1; b_dat = 32'hA1;
        step();
        b_mv = 1'b0;
        step();
        for (int i = 0; i < 40 && b_ts != 4'd0; i++) step();
        b_mv = 1'b1; b_dat = 32'hB2;
        step();
        b_mv = 1'b0;
        step();
        chk("wrap_fill", 64'(b_fill), 64'd2);
        chk("wrap_first", 64'(b_out), 64'({1'b0, 4'd15, 32'hA1}));
        b_rdy = 1'b1;
        step();
        b_rdy = 1'b0;
        chk("wrap_second", 64'(b_out), 64'({1'b0, 4'd0, 32'hB2}));

        // Asynchronous reset mid-burst.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) ev(32'h400 + 32'(i), i < 8);
        chk("pre_rst_ovf", 64'(overflow_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(trace_valid_o), 64'd0);
        chk("async_rst_data", 64'(trace_data_o), 64'd0);
        chk("async_rst_fill", 64'(fill_level_o), 64'd0);
        chk("async_rst_ovf", 64'(overflow_o), 64'd0);
        sb.delete();
        m_ts = '0; b_ts = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        trace_ready_i = 1'b1;
        ev(32'hFEED, 1'b1);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
